// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its skid buffer.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned COUNT_W = 2;
  localparam int unsigned DEPTH   = 2;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_BUSY  = 2'b01;
  localparam logic [1:0] MEM_VALID = 2'b10;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order buffer of fetched {inst, pc} pairs feeding decode.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [COUNT_W-1:0] count
);

  fetch_entry_t       entry0_q, entry0_d;
  fetch_entry_t       entry1_q, entry1_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               push_ok, pop_ok;

  assign push_ok = push && (count_q != COUNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Next-state: flush wins, otherwise shift on pop and append behind survivors.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      entry0_d = '0;
      entry1_d = '0;
      count_d  = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == '0) entry0_d = push_entry;
          else               entry1_d = push_entry;
          count_d = count_q + COUNT_W'(1);
        end
        2'b01: begin
          entry0_d = entry1_q;
          entry1_d = '0;
          count_d  = count_q - COUNT_W'(1);
        end
        2'b11: begin
          if (count_q == COUNT_W'(DEPTH)) begin
            entry0_d = entry1_q;
            entry1_d = push_entry;
          end else begin
            entry0_d = push_entry;
          end
        end
        default: ;
      endcase
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign head       = entry0_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch PC owner: issues addresses to instruction memory, buffers returned words
// for decode and aborts the in-flight access on redirect or a full buffer.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_abort,
  input  logic [XLEN-1:0] mem_r_data,
  input  logic [1:0]      mem_r_data_status,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            de_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc
);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [COUNT_W-1:0] count;
  logic               buf_full;
  logic               push, pop;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  assign buf_full = (count == COUNT_W'(DEPTH));

  // Abort must act in the same cycle, so it is decoded directly from its causes.
  assign mem_abort = !rst || redirect_valid || buf_full;
  assign mem_addr  = pc_q;

  // Status 11 is not MEM_VALID and therefore behaves as busy.
  assign push = (mem_r_data_status == MEM_VALID) && !redirect_valid && !buf_full;
  assign pop  = if_valid && de_ready && !redirect_valid;

  assign push_entry = '{inst: mem_r_data, pc: pc_q};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = align_pc(redirect_pc);
    else if (push)      pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  fetch_skid_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (if_valid),
    .count      (count)
  );

  assign if_inst = head.inst;
  assign if_pc   = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a latency-4 instruction memory model.
module tb_inst_fetch_unit;

  localparam int unsigned LAT = 4;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_abort;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_r_data_status;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        de_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  logic        ovr_en = 1'b0;
  logic [1:0]  ovr_status = 2'b00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_addr          (mem_addr),
    .mem_abort         (mem_abort),
    .mem_r_data        (mem_r_data),
    .mem_r_data_status (mem_r_data_status),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .de_ready          (de_ready),
    .if_valid          (if_valid),
    .if_inst           (if_inst),
    .if_pc             (if_pc)
  );

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model: abort forces idle; idle -> L+1 busy cycles -> one valid cycle.
  typedef enum logic [1:0] {M_IDLE = 2'b00, M_BUSY = 2'b01, M_VALID = 2'b10} mstate_t;
  mstate_t     m_state = M_IDLE;
  int unsigned m_cnt = 0;
  logic [31:0] m_addr = '0;

  always @(posedge clk) begin
    if (mem_abort) begin
      m_state <= M_IDLE;
      m_cnt   <= 0;
    end else begin
      case (m_state)
        M_IDLE:  begin m_state <= M_BUSY; m_cnt <= 0; m_addr <= mem_addr; end
        M_BUSY:  if (m_cnt == LAT) m_state <= M_VALID; else m_cnt <= m_cnt + 1;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  assign mem_r_data_status = ovr_en ? ovr_status : m_state;
  assign mem_r_data        = (m_state == M_VALID) ? word_of(m_addr) : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_if_valid(input string tag, input int budget);
    logic seen;
    seen = if_valid;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = if_valid;
    end
    checks++;
    assert (seen === 1'b1) else begin
      failures++;
      $error("FAIL %s timeout observed=%b expected=1", tag, seen);
    end
  endtask

  task automatic wait_status_valid(input string tag, input int budget);
    logic seen;
    seen = (mem_r_data_status == 2'b10);
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (mem_r_data_status == 2'b10);
    end
    checks++;
    assert (seen === 1'b1) else begin
      failures++;
      $error("FAIL %s timeout observed=%b expected=1", tag, seen);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    de_ready = 1'b1;
    tick();
    tick();
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_mem_abort", 32'(mem_abort), 32'h1);
    check("rst_mem_addr", mem_addr, RPC);

    // First fetch lands on the 7th edge after release, next one on the 14th
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_abort", 32'(mem_abort), 32'h0);
    repeat (6) tick();
    check("first_not_yet", 32'(if_valid), 32'h0);
    tick();
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_pc", if_pc, RPC);
    check("first_inst", if_inst, word_of(RPC));
    check("first_next_addr", mem_addr, RPC + 32'h4);
    repeat (6) tick();
    check("second_not_yet", 32'(if_valid), 32'h0);
    tick();
    check("second_valid", 32'(if_valid), 32'h1);
    check("second_pc", if_pc, RPC + 32'h4);
    check("second_inst", if_inst, word_of(RPC + 32'h4));

    // Decode stalled: buffer fills, memory held in abort
    rst = 1'b0;
    de_ready = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (30) tick();
    check("full_count", 32'(dut.count), 32'd2);
    check("full_head_pc", if_pc, RPC);
    check("full_head_inst", if_inst, word_of(RPC));
    check("full_abort", 32'(mem_abort), 32'h1);
    check("full_addr", mem_addr, RPC + 32'h8);

    de_ready = 1'b1;
    tick();
    check("pop1_pc", if_pc, RPC + 32'h4);
    check("pop1_count", 32'(dut.count), 32'd1);
    check("pop1_abort", 32'(mem_abort), 32'h0);
    tick();
    check("pop2_empty", 32'(if_valid), 32'h0);
    wait_if_valid("resume_wait", 20);
    check("resume_pc", if_pc, RPC + 32'h8);
    check("resume_inst", if_inst, word_of(RPC + 32'h8));
    de_ready = 1'b0;

    // Push and pop in the same cycle with one entry held
    wait_status_valid("pp_wait", 20);
    de_ready = 1'b1;
    tick();
    de_ready = 1'b0;
    check("pp_count", 32'(dut.count), 32'd1);
    check("pp_pc", if_pc, RPC + 32'hC);
    check("pp_inst", if_inst, word_of(RPC + 32'hC));

    // Redirect coinciding with a valid return drops the word
    wait_status_valid("redir_wait", 20);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    #1;
    check("redir_abort", 32'(mem_abort), 32'h1);
    tick();
    redirect_valid = 1'b0;
    check("redir_if_valid", 32'(if_valid), 32'h0);
    check("redir_count", 32'(dut.count), 32'd0);
    check("redir_addr", mem_addr, 32'h0000_1000);
    wait_if_valid("redir_fetch_wait", 20);
    check("redir_fetch_pc", if_pc, 32'h0000_1000);
    check("redir_fetch_inst", if_inst, word_of(32'h0000_1000));

    // Status 11 behaves as busy
    ovr_en = 1'b1;
    ovr_status = 2'b11;
    tick();
    ovr_en = 1'b0;
    check("st11_count", 32'(dut.count), 32'd1);
    check("st11_addr", mem_addr, 32'h0000_1004);

    // PC wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    check("wrap_empty", 32'(if_valid), 32'h0);
    wait_if_valid("wrap_wait", 20);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_inst", if_inst, word_of(32'hFFFF_FFFC));
    check("wrap_next_addr", mem_addr, 32'h0000_0000);

    // Reset pulsed mid-busy clears everything at once
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_if_valid", 32'(if_valid), 32'h0);
    check("mid_rst_if_pc", if_pc, 32'h0);
    check("mid_rst_abort", 32'(mem_abort), 32'h1);
    check("mid_rst_addr", mem_addr, RPC);
    check("mid_rst_count", 32'(dut.count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_push", 32'(if_valid), 32'h0);
    end
    tick();
    check("post_rst_valid", 32'(if_valid), 32'h1);
    check("post_rst_pc", if_pc, RPC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Requester side of the instruction-memory status protocol. Owns the fetch PC and drives the address into the instruction memory. Waits for a `2'b10` (valid) status, then buffers the returned word with its PC in a 2-entry skid buffer feeding decode. Handles branch/jump redirects by aborting the in-flight memory access. It sits between the instruction memory and the decode stage of the MIPS32 pipeline.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: PC loaded at reset.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_addr`  out  32  fetch address to instruction memory; always equals `pc`.
- `mem_abort`  out  1  drives the memory's `stall` input; clears the memory FSM when high.
- `mem_r_data`  in  32  instruction word from memory.
- `mem_r_data_status`  in  2  memory status: `00` idle, `01` busy, `10` data valid (one cycle), `11` unused.
- `redirect_valid`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `de_ready`  in  1  decode accepts the head entry this cycle.
- `if_valid`  out  1  head entry present.
- `if_inst`  out  32  head instruction.
- `if_pc`  out  32  PC of head instruction.

## Operation
- State: `pc`, a 2-entry buffer of {inst, pc}, and occupancy `count` (0..2).
- Reset (`rst`=0): `pc`=`RESET_PC`, `count`=0, entries cleared.
- Reset values of outputs: `if_valid`=0, `if_inst`=0, `if_pc`=0, `mem_abort`=1, `mem_addr`=`RESET_PC`.
- `mem_abort` is combinational: `!rst || redirect_valid || count==2`.
- Push: `mem_r_data_status==2'b10`, `!redirect_valid`, and `count<2`.
  - On push: write {`mem_r_data`, `pc`} to the tail entry and set `pc <= pc + 4`. The add wraps modulo 2^32.
- Pop: `if_valid && de_ready && !redirect_valid`. Removes the head; the second entry shifts to head.
- Simultaneous push and pop: `count` is unchanged. The new word goes behind the surviving entry; with `count` 1 it becomes the head.
- Redirect (has priority over everything):
  - `count <= 0`; `pc <= {redirect_pc[31:2], 2'b00}`.
  - A status `10` in the same cycle is discarded.
  - `mem_abort` is high in that cycle, so the memory restarts from idle with the new address.
- `count==2`: the memory is held in abort, so no new access starts. Fetch resumes the cycle after a pop lowers `count`.
- A defensive case: status `10` while `count==2` is discarded and `pc` is not advanced.
- `mem_addr` must stay stable for the whole busy phase. It changes only on push or redirect, and both coincide with the memory returning to idle.
- Status `11` is treated as busy.

## Timing
- Memory model (`latency_cycles`=L, default 4):
  - After `mem_abort` falls: 1 cycle idle, then L+1 cycles busy, then 1 cycle valid. Status `10` appears in cycle L+2 relative to the first cycle with abort low.
- Push happens at the end of the valid cycle; `if_valid` rises the next cycle.
- With L=4: first `if_valid` in cycle 7 after reset release.
- Steady state: one instruction per L+3 cycles. The next access overlaps with the held entry while `count<2`.
- Outputs `if_*` are registered; `de_ready` and `redirect_valid` only affect the next edge, except that `mem_abort` is immediate.
- Reset asserted mid-access: all state clears asynchronously and `mem_abort` is high at once, so there is no stale push.

## Structure
- Shared package `fetch_pkg`:
  - Status constants `MEM_IDLE`=2'b00, `MEM_BUSY`=2'b01, `MEM_VALID`=2'b10.
  - Typedef `fetch_entry_t` {inst[31:0], pc[31:0]}.
  - Default `RESET_PC`.
- One sub-module, `fetch_skid_buffer`: 2-entry buffer with push/pop/flush, head outputs, and `count`.
- The top level holds `pc`, the push/pop/abort logic, and the redirect path.

## Test plan
- Reset then release with `de_ready`=1 and L=4 → `if_valid` in cycle 7 with `if_pc`=`32'hBFC0_0000` and the word at that address. Next instruction at cycle 14 with `if_pc`=`32'hBFC0_0004`.
- `de_ready`=0 for 30 cycles → `count` reaches 2 holding PCs `BFC0_0000` and `BFC0_0004`, `mem_abort`=1, `mem_addr`=`BFC0_0008`. Raising `de_ready` pops in order and fetch resumes at `BFC0_0008`.
- `redirect_valid` with `redirect_pc`=`32'h0000_1003` in the same cycle as status `10` → word dropped, `if_valid`=0 next cycle. First new instruction has `if_pc`=`32'h0000_1000`.
- Simultaneous push and pop with `count`=1 → `count` stays 1 and the new word becomes the head the next cycle.
- `rst` pulsed low mid-busy → `if_valid`=0 immediately, `pc`=`RESET_PC`, and no push from the aborted access.
- `pc`=`32'hFFFF_FFFC` via redirect → after a push `mem_addr`=`32'h0000_0000`.
